collatz_sweep: RTL and testbench
================================

// Module: collatz_sweep
// PURPOSE
//  Upstream stimulus sequencer for the collatz test core (tests_collatz).
//  Issues a range of start values over the core's read/write handshake, one at a time.
//  Tracks the largest result and the input that produced it.
//  Replaces switch-driven single-shot stimulus for on-board range sweeps.
// PARAMETERS
//  TIMEOUT_CYCLES  4096  max cycles in WAIT per item (used only with COLLATZ_SWEEP_TIMEOUT_EN)
// PORTS
//  clk        in   1    system clock, all logic on posedge
//  rst        in   1    synchronous, active-high reset
//  start      in   1    begin sweep; sampled only in IDLE
//  first      in   27   first start value (`intT)
//  count      in   16   number of values to issue
//  core_read  out  1    one-cycle request strobe to core
//  core_a     out  27   start value to core; valid while core_read=1
//  core_b     in   27   core result; valid while core_write=1
//  core_write in   1    core result strobe
//  busy       out  1    high from accepted start until DONE
//  done       out  1    one-cycle pulse at sweep end
//  max_val    out  27   largest core_b seen this sweep
//  max_arg    out  27   core_a that produced max_val
//  issued     out  16   items completed this sweep
//  timed_out  out  1    sweep aborted by watchdog (0 when macro absent)
// BEHAVIOUR
//  Reset: state IDLE; core_read=0, busy=0, done=0, core_a=0, max_val=0, max_arg=0, issued=0, timed_out=0.
//  FSM IDLE -> ISSUE -> WAIT -> (ISSUE | DONE) -> IDLE.
//  IDLE: start=1 latches first/count, clears max_val/max_arg/issued/timed_out, busy=1.
//   count==0 goes straight to DONE; no core_read issued.
//  ISSUE: core_read=1 for exactly one cycle with core_a = current value; next state WAIT.
//  WAIT: on core_write: issued+1; if core_b > max_val (strict), max_val<=core_b, max_arg<=core_a.
//   Ties keep the earliest arg. Then if issued+1==count -> DONE, else core_a+1 -> ISSUE.
//  core_a increments mod 2^27 (0x7FFFFFF+1 wraps to 0). issued never wraps (count <= 65535).
//  Minimum per-item latency: ISSUE 1 cycle + core latency + 1 cycle.
//  DONE: done=1 for one cycle, busy=0, -> IDLE. Results hold until the next accepted start.
//  core_write outside WAIT is ignored, including a late strobe after reset or abort.
//  start while busy is ignored. start in the DONE cycle is ignored; it is accepted from the next IDLE cycle.
//  rst mid-sweep: immediate return to reset values; no partial done pulse.
// CONFIGURATION
//  COLLATZ_SWEEP_TIMEOUT_EN defined:
//   - cycle counter cleared on entry to WAIT.
//   - if TIMEOUT_CYCLES cycles elapse in WAIT without core_write: timed_out<=1 -> DONE.
//   - max_val, max_arg and issued keep the values reached so far.
//  Undefined: WAIT holds indefinitely; timed_out tied 0; no counter logic.
// STRUCTURE
//  Shared header (primitives.v): `intN/`intT width macros, `set/`reset helpers.
//  Local state encodings live in this module only.
//  One sub-module: collatz_sweep_watchdog (clear, enable, expired), instantiated only under the macro.
//  Peak compare/capture stays inline.
// TESTING
//  Use a behavioural core model: b = Collatz step count of a, write 3 cycles after read.
//  1 first=1 count=7 -> b=0,1,7,2,5,8,16; done pulse; max_val=16 max_arg=7 issued=7.
//  2 count=0 -> done one cycle after start; no core_read; max_val=0 issued=0.
//  3 model returns constant 5, first=10 count=4 -> max_val=5 max_arg=10 (tie keeps earliest).
//  4 first=0x7FFFFFF count=2 -> core_a sequence 0x7FFFFFF then 0x0000000; issued=2.
//  5 rst asserted during WAIT of item 3 of 7 -> next cycle all outputs at reset values.
//    Model write arriving afterwards is ignored; no done pulse.
//  6 COLLATZ_SWEEP_TIMEOUT_EN, TIMEOUT_CYCLES=16, model never writes on item 2:
//    done 16 cycles into WAIT; timed_out=1; issued=1.

Source files
------------

// File: rtl/collatz_sweep_pkg.sv
// Shared widths, peak record and compare helper for the collatz sweep sequencer.
package collatz_sweep_pkg;

  localparam int INT_W = 27;
  localparam int CNT_W = 16;

  typedef logic [INT_W-1:0] int_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    int_t val;
    int_t arg;
  } peak_t;

  // Strictly greater only, so a tie keeps the earliest argument.
  function automatic logic beats_peak(input int_t cand, input peak_t cur);
    return cand > cur.val;
  endfunction

endpackage

// File: rtl/collatz_sweep_watchdog.sv
// Per-item WAIT watchdog for collatz_sweep; only built when COLLATZ_SWEEP_TIMEOUT_EN is defined.
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
module collatz_sweep_watchdog #(
  parameter int unsigned CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Counter reads k-1 in the k-th WAIT cycle, so this fires on the CYCLES-th one.
  assign expired = enable && (cnt == W'(CYCLES - 1));

endmodule
`endif

// File: rtl/collatz_sweep.sv
// Range-sweep stimulus sequencer for the collatz core, tracking the peak result and its argument.
// Optional per-item watchdog is enabled by defining COLLATZ_SWEEP_TIMEOUT_EN.
module collatz_sweep
  import collatz_sweep_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [INT_W-1:0] first,
  input  logic [CNT_W-1:0] count,
  output logic             core_read,
  output logic [INT_W-1:0] core_a,
  input  logic [INT_W-1:0] core_b,
  input  logic             core_write,
  output logic             busy,
  output logic             done,
  output logic [INT_W-1:0] max_val,
  output logic [INT_W-1:0] max_arg,
  output logic [CNT_W-1:0] issued,
  output logic             timed_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0] state;
  cnt_t       count_q;
  peak_t      peak;
  cnt_t       issued_inc;

  assign issued_inc = issued + 1'b1;
  assign core_read  = (state == ST_ISSUE);
  assign busy       = (state == ST_ISSUE) || (state == ST_WAIT);
  assign done       = (state == ST_DONE);
  assign max_val    = peak.val;
  assign max_arg    = peak.arg;

`ifdef COLLATZ_SWEEP_TIMEOUT_EN
  logic wd_expired;
  logic timed_out_q;

  collatz_sweep_watchdog #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_ISSUE),
    .enable  (state == ST_WAIT),
    .expired (wd_expired)
  );

  assign timed_out = timed_out_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      count_q <= '0;
      core_a  <= '0;
      peak    <= '0;
      issued  <= '0;
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
      timed_out_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            count_q <= count;
            core_a  <= first;
            peak    <= '0;
            issued  <= '0;
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
            timed_out_q <= 1'b0;
`endif
            state   <= (count == '0) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        // A result write takes priority over a watchdog expiry in the same cycle.
        ST_WAIT: begin
          if (core_write) begin
            issued <= issued_inc;
            if (beats_peak(core_b, peak)) begin
              peak <= '{val: core_b, arg: core_a};
            end
            if (issued_inc == count_q) begin
              state <= ST_DONE;
            end else begin
              core_a <= core_a + 1'b1;
              state  <= ST_ISSUE;
            end
          end
`ifdef COLLATZ_SWEEP_TIMEOUT_EN
          else if (wd_expired) begin
            timed_out_q <= 1'b1;
            state       <= ST_DONE;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_sweep.sv
// Scoreboard bench for collatz_sweep with a behavioural collatz core (write 3 cycles after read).
module tb_collatz_sweep;

  typedef struct {
    logic [26:0] mv;
    logic [26:0] ma;
    logic [15:0] iss;
    logic        to;
  } done_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [26:0] first;
  logic [15:0] count;
  logic        core_read;
  logic [26:0] core_a;
  logic [26:0] core_b;
  logic        core_write;
  logic        busy;
  logic        done;
  logic [26:0] max_val;
  logic [26:0] max_arg;
  logic [15:0] issued;
  logic        timed_out;

  int checks   = 0;
  int failures = 0;

  logic [26:0] exp_a_q[$];
  done_t       exp_done_q[$];

  int          model_mode = 0;
  logic        drop_en    = 1'b0;
  logic [26:0] drop_a     = '0;
  int          pending    = 0;
  logic [26:0] pending_b  = '0;

  collatz_sweep #(
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first      (first),
    .count      (count),
    .core_read  (core_read),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_write (core_write),
    .busy       (busy),
    .done       (done),
    .max_val    (max_val),
    .max_arg    (max_arg),
    .issued     (issued),
    .timed_out  (timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [26:0] collatz_steps(input logic [26:0] a);
    longint unsigned n;
    int s;
    n = longint'(a);
    s = 0;
    while (n > 1) begin
      n = n[0] ? (3 * n + 1) : (n >> 1);
      s++;
    end
    return 27'(s);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic flagFail(input string name, input logic [31:0] actual);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=%0h expected=none", name, actual);
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 after the start cycle.
  task automatic applyStimulus(input logic [26:0] f, input logic [15:0] c);
    first = f;
    count = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) flagFail({name, "_done_timeout"}, 32'(n));
    @(posedge clk); #1;
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "_core_read"}, 32'(core_read), 32'd0);
    checkOutput({name, "_busy"},      32'(busy),      32'd0);
    checkOutput({name, "_done"},      32'(done),      32'd0);
    checkOutput({name, "_core_a"},    32'(core_a),    32'd0);
    checkOutput({name, "_max_val"},   32'(max_val),   32'd0);
    checkOutput({name, "_max_arg"},   32'(max_arg),   32'd0);
    checkOutput({name, "_issued"},    32'(issued),    32'd0);
    checkOutput({name, "_timed_out"}, 32'(timed_out), 32'd0);
  endtask

  task automatic checkDrained(input string name);
    checkOutput({name, "_reads_left"}, 32'(exp_a_q.size()),    32'd0);
    checkOutput({name, "_dones_left"}, 32'(exp_done_q.size()), 32'd0);
  endtask

  // Behavioural core: one outstanding item, result strobed 3 cycles after the read.
  initial begin
    core_write = 1'b0;
    core_b     = '0;
    forever begin
      @(posedge clk); #1;
      core_write = 1'b0;
      if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          core_b     = pending_b;
          core_write = 1'b1;
        end
      end
      if (core_read && !(drop_en && core_a == drop_a)) begin
        pending_b = (model_mode == 1) ? 27'd5 : collatz_steps(core_a);
        pending   = 3;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT strobes a read or a done.
  initial begin
    logic [26:0] ea;
    done_t       ed;
    forever begin
      @(posedge clk); #1;
      if (core_read) begin
        if (exp_a_q.size() == 0) flagFail("unexpected_core_read", 32'(core_a));
        else begin
          ea = exp_a_q.pop_front();
          checkOutput("core_a", 32'(core_a), 32'(ea));
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) flagFail("unexpected_done", 32'(issued));
        else begin
          ed = exp_done_q.pop_front();
          checkOutput("done_max_val",   32'(max_val),   32'(ed.mv));
          checkOutput("done_max_arg",   32'(max_arg),   32'(ed.ma));
          checkOutput("done_issued",    32'(issued),    32'(ed.iss));
          checkOutput("done_timed_out", 32'(timed_out), 32'(ed.to));
          checkOutput("done_busy_low",  32'(busy),      32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int n;
    logic saw_done;
    rst   = 1'b1;
    start = 1'b0;
    first = '0;
    count = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkIdleOutputs("reset");

    // Sweep 1..7: b = 0,1,7,2,5,8,16
    $display("[TB] sweep first=1 count=7");
    model_mode = 0;
    for (int i = 1; i <= 7; i++) exp_a_q.push_back(27'(i));
    exp_done_q.push_back('{mv: 27'd16, ma: 27'd7, iss: 16'd7, to: 1'b0});
    applyStimulus(27'd1, 16'd7);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    applyStimulus(27'd100, 16'd1);
    waitDone("t1", 200);
    checkOutput("t1_hold_max_val", 32'(max_val), 32'd16);
    checkOutput("t1_hold_issued",  32'(issued),  32'd7);
    checkDrained("t1");

    // Zero-length sweep goes straight to DONE
    $display("[TB] sweep count=0");
    exp_done_q.push_back('{mv: 27'd0, ma: 27'd0, iss: 16'd0, to: 1'b0});
    applyStimulus(27'd5, 16'd0);
    checkOutput("t2_done_next", 32'(done), 32'd1);
    @(posedge clk); #1;
    checkOutput("t2_done_one_cycle", 32'(done), 32'd0);
    checkDrained("t2");

    // Constant result: ties keep the earliest argument
    $display("[TB] sweep const model first=10 count=4");
    model_mode = 1;
    for (int i = 10; i <= 13; i++) exp_a_q.push_back(27'(i));
    exp_done_q.push_back('{mv: 27'd5, ma: 27'd10, iss: 16'd4, to: 1'b0});
    applyStimulus(27'd10, 16'd4);
    waitDone("t3", 200);
    checkDrained("t3");

    // core_a wraps mod 2^27
    $display("[TB] sweep wrap first=7ffffff count=2");
    exp_a_q.push_back(27'h7FFFFFF);
    exp_a_q.push_back(27'h0000000);
    exp_done_q.push_back('{mv: 27'd5, ma: 27'h7FFFFFF, iss: 16'd2, to: 1'b0});
    applyStimulus(27'h7FFFFFF, 16'd2);
    waitDone("t4", 200);
    checkDrained("t4");

    // Reset during WAIT of item 3; the late core write must be ignored
    $display("[TB] reset mid-sweep");
    model_mode = 0;
    for (int i = 1; i <= 3; i++) exp_a_q.push_back(27'(i));
    applyStimulus(27'd1, 16'd7);
    n = 0;
    while (!(core_read && core_a == 27'd3) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) flagFail("t5_item3_timeout", 32'(n));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkIdleOutputs("t5_after_rst");
    saw_done = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    checkOutput("t5_no_done", 32'(saw_done), 32'd0);
    checkIdleOutputs("t5_late_write");
    checkDrained("t5");

`ifdef COLLATZ_SWEEP_TIMEOUT_EN
    // Core never answers item 2 (a=4): watchdog ends the sweep after 16 WAIT cycles
    $display("[TB] watchdog sweep first=3 count=4");
    drop_en = 1'b1;
    drop_a  = 27'd4;
    exp_a_q.push_back(27'd3);
    exp_a_q.push_back(27'd4);
    exp_done_q.push_back('{mv: 27'd7, ma: 27'd3, iss: 16'd1, to: 1'b1});
    applyStimulus(27'd3, 16'd4);
    n = 0;
    while (!(core_read && core_a == 27'd4) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) flagFail("t6_item2_timeout", 32'(n));
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("t6_done_latency", 32'(n), 32'd17);
    @(posedge clk); #1;
    checkOutput("t6_hold_timed_out", 32'(timed_out), 32'd1);
    checkDrained("t6");
    drop_en = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
